uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receiver that consumes the 8E1 UART stream produced by the team's transmitter: 1 start bit, 8 data bits LSB-first, 1 even-parity bit, 1 stop bit.
- Sits at the FPGA boundary on a GPIO input pin.
- Delivers each received byte as a one-cycle valid strobe, together with parity and framing status, to downstream logic (LED display or loopback checker).

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115_200, line bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (434), clocks per bit period; derived, not overridden.
- HALF_BIT, CLKS_PER_BIT/2 (217), offset from the start edge to the start-bit centre.

Ports:
- MAX10_CLK1_50  in   1  system clock; all logic on its rising edge.
- rst            in   1  synchronous, active-high reset.
- rx_in          in   1  asynchronous serial line, idle high.
- rx_data        out  8  last received byte; held until the next frame completes.
- rx_valid       out  1  one-cycle pulse when rx_data, parity_err and frame_err update.
- parity_err     out  1  1 = the received parity bit does not give even parity over data plus parity; held with rx_data.
- frame_err      out  1  1 = stop bit sampled low; held with rx_data.
- busy           out  1  1 whenever the state is not IDLE.

Behaviour:
- Input synchroniser: 2-flop chain on rx_in, both flops reset to 1. All decisions use the second-flop output (rx_s).
- Reset values: state RECOVER; rx_data 0x00; rx_valid 0; parity_err 0; frame_err 0; busy 1; bit counter 0; clock counter 0.
- Reset asserted mid-frame discards the partial frame with no rx_valid pulse.
- One clock counter (range 0..CLKS_PER_BIT-1) and a 3-bit data index.
- States:
  - RECOVER: wait for rx_s==1, then go to IDLE. Prevents a line held low after reset or after a framing error from being taken as a start bit.
  - IDLE: clock counter held at 0. rx_s==0 -> START.
  - START: count until counter==HALF_BIT-1, then sample rx_s.
    - rx_s==1: glitch. Go to IDLE with no output activity.
    - rx_s==0: clear counter, go to DATA with index 0.
  - DATA: count until counter==CLKS_PER_BIT-1, then sample rx_s into shift bit [index] (LSB first) and clear counter.
    - index==7 -> PARITY.
    - otherwise index+1.
  - PARITY: at counter==CLKS_PER_BIT-1, sample and store the parity bit, clear counter, go to STOP.
  - STOP: at counter==CLKS_PER_BIT-1, sample the stop bit. In the same edge register:
    - rx_data <= shift register;
    - parity_err <= XOR(data, parity bit);
    - frame_err <= ~stop sample;
    - rx_valid <= 1 for exactly one cycle.
    - Next state: IDLE if the stop sample is 1, RECOVER if it is 0.
- Sampling point: every bit after START is sampled at its centre. Leaving STOP half a bit early lets a start bit that immediately follows be detected with no gap.
- rx_valid is asserted (1 + HALF_BIT + 10*CLKS_PER_BIT) = 4558 cycles after the first IDLE cycle that sees rx_s==0. It is never asserted for a glitch-rejected start.
- A frame with a parity error or framing error still pulses rx_valid. The error flags qualify that byte.
- The error flags and rx_data change only on the rx_valid cycle. They never self-clear.
- busy = (state != IDLE). busy therefore reads 1 during RECOVER.
- Width rules: the counter is 16 bits and compares against localparams. The data index cannot exceed 7.

Test Plan:
- Release reset with rx_in=1, wait 10 cycles. Drive 0xA5 as 8E1 at 434 clk/bit (parity bit 0) -> exactly one rx_valid pulse, rx_data=0xA5, parity_err=0, frame_err=0, pulse within 4558..4560 cycles of the start edge at the pin, busy=0 afterwards.
- Drive 0x01 with parity bit 0 (wrong) -> rx_valid pulse, rx_data=0x01, parity_err=1, frame_err=0. Then send a correct 0x03 (parity 0) -> parity_err returns to 0.
- Drive 0x3C with stop bit 0, then hold rx_in low 2000 cycles -> rx_valid pulse with frame_err=1, busy stays 1 with no further rx_valid while low. Raise rx_in, then send 0x55 -> rx_data=0x55, frame_err=0.
- Drive a 100-cycle low glitch on idle rx_in -> no rx_valid, state back to IDLE (busy=0) within 220 cycles of the glitch start.
- Send 0x00 then 0xFF back-to-back, with the second start bit beginning immediately after the first stop bit -> two rx_valid pulses 4774 (11*434) cycles apart, data 0x00 then 0xFF, both error-free.
- Assert rst for 1 cycle during DATA of a frame -> no rx_valid for that frame, all outputs at reset values. A following clean 0x81 (parity 0) is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receive-side bus of the 8E1 UART receiver: byte, strobe, status flags, busy.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    // The receiver drives the bus.
    modport master (
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        output busy
    );

    // Downstream logic (display, loopback checker) consumes it.
    modport slave (
        input rx_data,
        input rx_valid,
        input parity_err,
        input frame_err,
        input busy
    );
endinterface : uart_rx_if

// File: rtl/uart_rx.sv
// 8E1 UART receiver: 1 start, 8 data LSB-first, even parity, 1 stop.
// Each bit after the start bit is sampled at its centre; a completed frame
// produces a one-cycle rx_valid strobe with data and parity/framing status.
module uart_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic      MAX10_CLK1_50,
    input  logic      rst,
    input  logic      rx_in,
    uart_rx_if.master rx_bus
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;

    localparam logic [15:0] CNT_BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] CNT_HALF_LAST = 16'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        ST_RECOVER = 3'd0,
        ST_IDLE    = 3'd1,
        ST_START   = 3'd2,
        ST_DATA    = 3'd3,
        ST_PARITY  = 3'd4,
        ST_STOP    = 3'd5
    } state_t;

    // Returns 1 when data plus parity bit do not hold an even number of ones.
    function automatic logic even_parity_err(input logic [7:0] data, input logic pbit);
        return ^{data, pbit};
    endfunction

    logic        sync1_q;
    logic        sync2_q;
    logic        rx_s;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [2:0]  idx_q;
    logic [7:0]  shift_q;
    logic        pbit_q;

    logic [7:0]  rx_data_q;
    logic        rx_valid_q;
    logic        parity_err_q;
    logic        frame_err_q;

    // Two-flop synchroniser on the asynchronous line; resets to idle-high.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    // Frame FSM: bit timing, shifting, and registered result/status outputs.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (rst) begin
            state_q      <= ST_RECOVER;
            cnt_q        <= 16'd0;
            idx_q        <= 3'd0;
            shift_q      <= 8'h00;
            pbit_q       <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                // Line must be seen high before a falling edge can mean a start bit.
                ST_RECOVER: begin
                    cnt_q <= 16'd0;
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_RECOVER;
                    end
                end
                ST_IDLE: begin
                    cnt_q <= 16'd0;
                    if (!rx_s) begin
                        state_q <= ST_START;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                // Re-check the line at the start-bit centre to reject glitches.
                ST_START: begin
                    if (cnt_q == CNT_HALF_LAST) begin
                        cnt_q <= 16'd0;
                        if (rx_s) begin
                            state_q <= ST_IDLE;
                        end else begin
                            idx_q   <= 3'd0;
                            state_q <= ST_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CNT_BIT_LAST) begin
                        cnt_q          <= 16'd0;
                        shift_q[idx_q] <= rx_s;
                        if (idx_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_PARITY: begin
                    if (cnt_q == CNT_BIT_LAST) begin
                        cnt_q   <= 16'd0;
                        pbit_q  <= rx_s;
                        state_q <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                // Leaving at the stop-bit centre leaves half a bit to catch a
                // start bit that follows with no idle gap.
                ST_STOP: begin
                    if (cnt_q == CNT_BIT_LAST) begin
                        cnt_q        <= 16'd0;
                        rx_data_q    <= shift_q;
                        parity_err_q <= even_parity_err(shift_q, pbit_q);
                        frame_err_q  <= ~rx_s;
                        rx_valid_q   <= 1'b1;
                        if (rx_s) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_RECOVER;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= ST_RECOVER;
                    cnt_q   <= 16'd0;
                end
            endcase
        end
    end

    assign rx_bus.rx_data    = rx_data_q;
    assign rx_bus.rx_valid   = rx_valid_q;
    assign rx_bus.parity_err = parity_err_q;
    assign rx_bus.frame_err  = frame_err_q;
    assign rx_bus.busy       = (state_q != ST_IDLE);

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed and randomized 8E1 frames checked against a
// frame-level reference model (popcount parity, stop level, latency window).
module tb_uart_rx;

    localparam int CPB       = 434;
    localparam int LAT_MIN   = 4558;
    localparam int LAT_MAX   = 4560;
    localparam int FRAME_CYC = 11 * CPB;

    logic clk;
    logic rst;
    logic rx_in;
    int   cyc;
    int   n_checks;
    int   n_errors;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         t;
    } ev_t;

    ev_t evq[$];

    uart_rx_if bus ();

    uart_rx dut (
        .MAX10_CLK1_50 (clk),
        .rst           (rst),
        .rx_in         (rx_in),
        .rx_bus        (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Cycle counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Record every rx_valid-high cycle with its outputs and time.
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            evq.push_back('{d: bus.rx_data, pe: bus.parity_err, fe: bus.frame_err, t: cyc});
        end
    end

    // Hard time limit so the run always terminates.
    initial begin
        #(20 * 90_000);
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: error when data plus parity bit hold an odd count of ones.
    function automatic logic model_perr(input logic [7:0] d, input logic p);
        return (($countones(d) + int'(p)) % 2) != 0;
    endfunction

    // Bit-bang one frame starting on a falling clock edge; returns its start cycle.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, output int t0);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        t0 = cyc;
        for (int i = 0; i < 11; i++) begin
            rx_in = bits[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic pop_check(input string tag, input logic [7:0] d, input logic p, input logic s, input int t0);
        ev_t e;
        int  lat;
        if (evq.size() > 0) begin
            e   = evq.pop_front();
            lat = e.t - t0;
            check_eq({tag, "_data"}, e.d, d);
            check_eq({tag, "_perr"}, e.pe, model_perr(d, p));
            check_eq({tag, "_ferr"}, e.fe, !s);
            check_eq({tag, "_lat_in_window"}, (lat >= LAT_MIN && lat <= LAT_MAX), 1'b1);
        end else begin
            check_eq({tag, "_present"}, 0, 1);
        end
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] d, input logic p, input logic s, input int t0);
        check_eq({tag, "_nvalid"}, evq.size(), 1);
        pop_check(tag, d, p, s, t0);
    endtask

    initial begin
        int         t0;
        int         t1;
        ev_t        e0;
        logic [7:0] rd;
        logic       rp;
        logic       rs;

        cyc      = 0;
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        rx_in    = 1'b1;
        repeat (3) @(negedge clk);

        check_eq("rst_data", bus.rx_data, 8'h00);
        check_eq("rst_valid", bus.rx_valid, 1'b0);
        check_eq("rst_perr", bus.parity_err, 1'b0);
        check_eq("rst_ferr", bus.frame_err, 1'b0);
        check_eq("rst_busy", bus.busy, 1'b1);

        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("idle_busy", bus.busy, 1'b0);

        // Clean 0xA5.
        send_frame(8'hA5, 1'b0, 1'b1, t0);
        expect_frame("a5", 8'hA5, 1'b0, 1'b1, t0);
        check_eq("a5_busy_after", bus.busy, 1'b0);

        // Wrong parity on 0x01, then a clean 0x03 clears the flag.
        send_frame(8'h01, 1'b0, 1'b1, t0);
        expect_frame("p01", 8'h01, 1'b0, 1'b1, t0);
        send_frame(8'h03, 1'b0, 1'b1, t0);
        expect_frame("p03", 8'h03, 1'b0, 1'b1, t0);

        // Framing error, line held low, then recovery with 0x55.
        send_frame(8'h3C, 1'b0, 1'b0, t0);
        expect_frame("f3c", 8'h3C, 1'b0, 1'b0, t0);
        rx_in = 1'b0;
        repeat (2000) @(negedge clk);
        check_eq("low_busy", bus.busy, 1'b1);
        check_eq("low_nvalid", evq.size(), 0);
        check_eq("low_ferr_held", bus.frame_err, 1'b1);
        rx_in = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("recover_busy", bus.busy, 1'b0);
        send_frame(8'h55, 1'b0, 1'b1, t0);
        expect_frame("r55", 8'h55, 1'b0, 1'b1, t0);

        // 100-cycle glitch: rejected, idle again 220 cycles after its start.
        rx_in = 1'b0;
        repeat (100) @(negedge clk);
        rx_in = 1'b1;
        repeat (120) @(negedge clk);
        check_eq("glitch_busy", bus.busy, 1'b0);
        repeat (50) @(negedge clk);
        check_eq("glitch_nvalid", evq.size(), 0);

        // Back-to-back 0x00 and 0xFF with no idle gap.
        send_frame(8'h00, 1'b0, 1'b1, t0);
        send_frame(8'hFF, 1'b0, 1'b1, t1);
        check_eq("b2b_nvalid", evq.size(), 2);
        if (evq.size() == 2) begin
            e0 = evq[0];
            check_eq("b2b_spacing", evq[1].t - e0.t, FRAME_CYC);
        end
        pop_check("b2b0", 8'h00, 1'b0, 1'b1, t0);
        pop_check("b2b1", 8'hFF, 1'b0, 1'b1, t1);

        // Reset pulse in the middle of the data bits.
        rx_in = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_data", bus.rx_data, 8'h00);
        check_eq("mid_rst_valid", bus.rx_valid, 1'b0);
        check_eq("mid_rst_perr", bus.parity_err, 1'b0);
        check_eq("mid_rst_ferr", bus.frame_err, 1'b0);
        check_eq("mid_rst_busy", bus.busy, 1'b1);
        rst   = 1'b0;
        rx_in = 1'b1;
        repeat (1000) @(negedge clk);
        check_eq("mid_rst_nvalid", evq.size(), 0);
        send_frame(8'h81, 1'b0, 1'b1, t0);
        expect_frame("a81", 8'h81, 1'b0, 1'b1, t0);

        // Randomized frames: random byte, random parity correctness, mostly good stop.
        for (int k = 0; k < 4; k++) begin
            rd = 8'($urandom_range(0, 255));
            rp = 1'(($countones(rd) + int'($urandom_range(0, 1))) % 2);
            rs = ($urandom_range(0, 3) != 0);
            send_frame(rd, rp, rs, t0);
            expect_frame("rnd", rd, rp, rs, t0);
            rx_in = 1'b1;
            repeat (10) @(negedge clk);
            check_eq("rnd_busy_after", bus.busy, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_uart_rx
